// File: rtl/noc_tg_pkg.sv
// Shared definitions for the NoC traffic generator.
// Holds flit field widths/offsets, the destination pattern enum, and a flit packing helper.
// Flit layout, MSB to LSB: {payload, dst_y, dst_x, src_y, src_x}.
package noc_tg_pkg;

  localparam int unsigned X_W     = 2;
  localparam int unsigned Y_W     = 2;
  localparam int unsigned DATA_W  = 8;
  localparam int unsigned TOTAL_W = DATA_W + 2 * (X_W + Y_W);
  localparam int unsigned CNT_W   = 16;
  localparam int unsigned GAP_W   = 8;

  localparam int unsigned SRC_X_OFF   = 0;
  localparam int unsigned SRC_Y_OFF   = X_W;
  localparam int unsigned DST_X_OFF   = X_W + Y_W;
  localparam int unsigned DST_Y_OFF   = 2 * X_W + Y_W;
  localparam int unsigned PAYLOAD_OFF = 2 * (X_W + Y_W);

  typedef enum logic [1:0] {
    PatUniform   = 2'd0,
    PatTranspose = 2'd1,
    PatBitComp   = 2'd2,
    PatHotspot   = 2'd3
  } pattern_e;

  function automatic logic [TOTAL_W-1:0] pack_flit(input logic [DATA_W-1:0] payload,
                                                   input logic [Y_W-1:0]    dst_y,
                                                   input logic [X_W-1:0]    dst_x,
                                                   input logic [Y_W-1:0]    src_y,
                                                   input logic [X_W-1:0]    src_x);
    return {payload, dst_y, dst_x, src_y, src_x};
  endfunction

endpackage

// File: rtl/noc_tg_lfsr.sv
// 16-bit Galois LFSR, polynomial x^16 + x^14 + x^13 + x^11 + 1 (right-shifting form).
// Ports: clk_i clock; rst_ni synchronous active-low reset, loads Seed; adv_i steps once;
//        state_o current register value.
module noc_tg_lfsr #(
  parameter logic [15:0] Seed = 16'hACE1
) (
  input  logic        clk_i,
  input  logic        rst_ni,
  input  logic        adv_i,
  output logic [15:0] state_o
);

  localparam logic [15:0] Taps = 16'hB400;

  logic [15:0] lfsr_q, lfsr_d;

  always_comb begin
    lfsr_d = lfsr_q;
    if (adv_i) begin
      lfsr_d = {1'b0, lfsr_q[15:1]} ^ (lfsr_q[0] ? Taps : 16'h0000);
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      lfsr_q <= Seed;
    end else begin
      lfsr_q <= lfsr_d;
    end
  end

  assign state_o = lfsr_q;

endmodule

// File: rtl/noc_traffic_gen.sv
// Per-node mesh traffic injector/sink. Injects a programmed number of flits on a valid/ready
// port with a fixed inter-flit gap and one of four destination patterns; counts ejected flits.
// Ports: clk/rstn (sync, active low); i_start/i_pattern/i_num_pkts/i_gap/i_src_x/i_src_y run
//        config; o_data/o_data_valid/i_data_ready injection port; i_data/i_data_valid ejection;
//        o_busy/o_done status; o_tx_count/o_rx_count/o_err_count counters.
// Optional: define NOC_TG_CHECK_EN to count ejected flits whose dst differs from i_src_x/y.
module noc_traffic_gen
  import noc_tg_pkg::*;
#(
  parameter int unsigned X     = 4,
  parameter int unsigned Y     = 4,
  parameter int unsigned HOT_X = 0,
  parameter int unsigned HOT_Y = 0,
  parameter logic [15:0] SEED  = 16'hACE1
) (
  input  logic               clk,
  input  logic               rstn,
  input  logic               i_start,
  input  logic [1:0]         i_pattern,
  input  logic [CNT_W-1:0]   i_num_pkts,
  input  logic [GAP_W-1:0]   i_gap,
  input  logic [X_W-1:0]     i_src_x,
  input  logic [Y_W-1:0]     i_src_y,
  output logic [TOTAL_W-1:0] o_data,
  output logic               o_data_valid,
  input  logic               i_data_ready,
  input  logic [TOTAL_W-1:0] i_data,
  input  logic               i_data_valid,
  output logic               o_busy,
  output logic               o_done,
  output logic [CNT_W-1:0]   o_tx_count,
  output logic [CNT_W-1:0]   o_rx_count,
  output logic [CNT_W-1:0]   o_err_count
);

  typedef enum logic [1:0] {StIdle, StGen, StGap, StDone} state_e;

  localparam logic [CNT_W-1:0]  CntOne = CNT_W'(1);
  localparam logic [GAP_W-1:0]  GapOne = GAP_W'(1);
  localparam logic [DATA_W-1:0] SeqOne = DATA_W'(1);

  state_e              state_q, state_d;
  pattern_e            pattern_q, pattern_d;
  logic [CNT_W-1:0]    num_q, num_d;
  logic [GAP_W-1:0]    gap_q, gap_d;
  logic [GAP_W-1:0]    gap_cnt_q, gap_cnt_d;
  logic [X_W-1:0]      src_x_q, src_x_d;
  logic [Y_W-1:0]      src_y_q, src_y_d;
  logic [CNT_W-1:0]    tx_cnt_q, tx_cnt_d;
  logic [CNT_W-1:0]    rx_cnt_q, rx_cnt_d;
  logic [DATA_W-1:0]   seq_q, seq_d;
  logic                lfsr_adv;
  logic [15:0]         lfsr;
  logic [X_W-1:0]      dst_x;
  logic [Y_W-1:0]      dst_y;

  noc_tg_lfsr #(
    .Seed (SEED)
  ) u_lfsr (
    .clk_i   (clk),
    .rst_ni  (rstn),
    .adv_i   (lfsr_adv),
    .state_o (lfsr)
  );

  // Destination depends only on registered state, so it stays stable while a flit is stalled.
  always_comb begin
    dst_x = '0;
    dst_y = '0;
    unique case (pattern_q)
      PatUniform: begin
        dst_x = X_W'(32'(lfsr[X_W-1:0]) % X);
        dst_y = Y_W'(32'(lfsr[X_W +: Y_W]) % Y);
        if (dst_x == src_x_q && dst_y == src_y_q) begin
          dst_x = X_W'((32'(src_x_q) + 1) % X);
        end
      end
      PatTranspose: begin
        dst_x = X_W'(src_y_q);
        dst_y = Y_W'(src_x_q);
      end
      PatBitComp: begin
        dst_x = X_W'(X - 1 - 32'(src_x_q));
        dst_y = Y_W'(Y - 1 - 32'(src_y_q));
      end
      PatHotspot: begin
        dst_x = X_W'(HOT_X);
        dst_y = Y_W'(HOT_Y);
      end
      default: ;
    endcase
  end

  always_comb begin
    state_d   = state_q;
    pattern_d = pattern_q;
    num_d     = num_q;
    gap_d     = gap_q;
    gap_cnt_d = gap_cnt_q;
    src_x_d   = src_x_q;
    src_y_d   = src_y_q;
    tx_cnt_d  = tx_cnt_q;
    seq_d     = seq_q;
    lfsr_adv  = 1'b0;
    unique case (state_q)
      StIdle, StDone: begin
        if (i_start) begin
          pattern_d = pattern_e'(i_pattern);
          num_d     = i_num_pkts;
          gap_d     = i_gap;
          src_x_d   = i_src_x;
          src_y_d   = i_src_y;
          tx_cnt_d  = '0;
          seq_d     = '0;
          state_d   = (i_num_pkts == '0) ? StDone : StGen;
        end
      end
      StGen: begin
        if (i_data_ready) begin
          tx_cnt_d = tx_cnt_q + CntOne;
          seq_d    = seq_q + SeqOne;
          lfsr_adv = 1'b1;
          if (tx_cnt_q + CntOne == num_q) begin
            state_d = StDone;
          end else if (gap_q != '0) begin
            gap_cnt_d = gap_q;
            state_d   = StGap;
          end
        end
      end
      StGap: begin
        if (gap_cnt_q <= GapOne) begin
          state_d = StGen;
        end else begin
          gap_cnt_d = gap_cnt_q - GapOne;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_comb begin
    rx_cnt_d = rx_cnt_q;
    if (i_data_valid && rx_cnt_q != '1) begin
      rx_cnt_d = rx_cnt_q + CntOne;
    end
  end

  always_ff @(posedge clk) begin
    if (!rstn) begin
      state_q   <= StIdle;
      pattern_q <= PatUniform;
      num_q     <= '0;
      gap_q     <= '0;
      gap_cnt_q <= '0;
      src_x_q   <= '0;
      src_y_q   <= '0;
      tx_cnt_q  <= '0;
      rx_cnt_q  <= '0;
      seq_q     <= '0;
    end else begin
      state_q   <= state_d;
      pattern_q <= pattern_d;
      num_q     <= num_d;
      gap_q     <= gap_d;
      gap_cnt_q <= gap_cnt_d;
      src_x_q   <= src_x_d;
      src_y_q   <= src_y_d;
      tx_cnt_q  <= tx_cnt_d;
      rx_cnt_q  <= rx_cnt_d;
      seq_q     <= seq_d;
    end
  end

`ifdef NOC_TG_CHECK_EN
  logic [CNT_W-1:0] err_cnt_q, err_cnt_d;
  logic             rx_misroute;

  assign rx_misroute = (i_data[DST_X_OFF +: X_W] != i_src_x) ||
                       (i_data[DST_Y_OFF +: Y_W] != i_src_y);

  always_comb begin
    err_cnt_d = err_cnt_q;
    if (i_data_valid && rx_misroute && err_cnt_q != '1) begin
      err_cnt_d = err_cnt_q + CntOne;
    end
  end

  always_ff @(posedge clk) begin
    if (!rstn) begin
      err_cnt_q <= '0;
    end else begin
      err_cnt_q <= err_cnt_d;
    end
  end

  assign o_err_count = err_cnt_q;
`else
  assign o_err_count = '0;
`endif

  // Ejected payload/src fields and high LFSR bits are intentionally not consumed.
  logic unused_rx_data;
  logic unused_lfsr;
  assign unused_rx_data = ^i_data;
  assign unused_lfsr    = ^lfsr[15:X_W+Y_W];

  assign o_data_valid = (state_q == StGen);
  assign o_data       = o_data_valid ? pack_flit(seq_q, dst_y, dst_x, src_y_q, src_x_q) : '0;
  assign o_busy       = (state_q == StGen) || (state_q == StGap);
  assign o_done       = (state_q == StDone);
  assign o_tx_count   = tx_cnt_q;
  assign o_rx_count   = rx_cnt_q;

endmodule

// File: tb/tb_noc_traffic_gen.sv
// Scoreboard bench for noc_traffic_gen: the driver pushes model-predicted flits per run,
// a negedge monitor pops and compares every accepted flit, checks stall stability and gaps.
module tb_noc_traffic_gen;
  import noc_tg_pkg::*;

  logic               clk = 1'b0;
  logic               rstn;
  logic               i_start;
  logic [1:0]         i_pattern;
  logic [CNT_W-1:0]   i_num_pkts;
  logic [GAP_W-1:0]   i_gap;
  logic [X_W-1:0]     i_src_x;
  logic [Y_W-1:0]     i_src_y;
  logic [TOTAL_W-1:0] o_data;
  logic               o_data_valid;
  logic               i_data_ready = 1'b0;
  logic [TOTAL_W-1:0] i_data;
  logic               i_data_valid;
  logic               o_busy;
  logic               o_done;
  logic [CNT_W-1:0]   o_tx_count;
  logic [CNT_W-1:0]   o_rx_count;
  logic [CNT_W-1:0]   o_err_count;

  always #5 clk = ~clk;

  noc_traffic_gen dut (
    .clk          (clk),
    .rstn         (rstn),
    .i_start      (i_start),
    .i_pattern    (i_pattern),
    .i_num_pkts   (i_num_pkts),
    .i_gap        (i_gap),
    .i_src_x      (i_src_x),
    .i_src_y      (i_src_y),
    .o_data       (o_data),
    .o_data_valid (o_data_valid),
    .i_data_ready (i_data_ready),
    .i_data       (i_data),
    .i_data_valid (i_data_valid),
    .o_busy       (o_busy),
    .o_done       (o_done),
    .o_tx_count   (o_tx_count),
    .o_rx_count   (o_rx_count),
    .o_err_count  (o_err_count)
  );

  int n_pass  = 0;
  int n_total = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  // Reference model state
  int          exp_q[$];
  int          cur_gap = 0;
  logic [15:0] m_lfsr  = 16'hACE1;
  int          m_rx    = 0;
  int          m_err   = 0;

  function automatic logic [15:0] lfsr_next(input logic [15:0] s);
    return (s >> 1) ^ (s[0] ? 16'hB400 : 16'h0000);
  endfunction

  // 0: ready low, 1: ready high, 2: random
  int ready_mode = 1;
  always @(posedge clk) begin
    #2;
    case (ready_mode)
      0: i_data_ready = 1'b0;
      1: i_data_ready = 1'b1;
      default: i_data_ready = 1'($urandom_range(0, 1));
    endcase
  end

  // Monitor
  bit          held_v   = 0;
  logic [15:0] held_d;
  bit          counting = 0;
  int          idle     = 0;
  always @(negedge clk) begin
    if (!rstn) begin
      held_v   = 0;
      counting = 0;
    end else if (o_data_valid) begin
      if (held_v) check("stall_data_stable", 32'(o_data), 32'(held_d));
      if (counting) begin
        check("gap_len", idle, cur_gap);
        counting = 0;
      end
      if (exp_q.size() == 0) begin
        n_total++;
        $display("FAIL unexpected_flit: got %0h expected none", o_data);
        held_v = 0;
      end else if (i_data_ready) begin
        check("flit", 32'(o_data), 32'(exp_q.pop_front()));
        held_v = 0;
        if (exp_q.size() > 0) begin
          counting = 1;
          idle     = 0;
        end
      end else begin
        held_v = 1;
        held_d = o_data;
      end
    end else begin
      if (held_v) begin
        check("valid_retracted", 32'(o_data_valid), 32'd1);
        held_v = 0;
      end
      if (counting) begin
        idle++;
        check("busy_in_gap", 32'(o_busy), 32'd1);
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic run(input int pat, input int sx, input int sy, input int num, input int gap);
    int dx, dy;
    for (int i = 0; i < num; i++) begin
      case (pat)
        0: begin
          dx = int'(m_lfsr & 16'h3) % 4;
          dy = int'((m_lfsr >> 2) & 16'h3) % 4;
          if (dx == sx && dy == sy) dx = (sx + 1) % 4;
        end
        1: begin dx = sy; dy = sx; end
        2: begin dx = 3 - sx; dy = 3 - sy; end
        default: begin dx = 0; dy = 0; end
      endcase
      exp_q.push_back(((i % 256) << 8) | (dy << 6) | (dx << 4) | (sy << 2) | sx);
      m_lfsr = lfsr_next(m_lfsr);
    end
    cur_gap    = gap;
    i_pattern  = 2'(pat);
    i_src_x    = X_W'(sx);
    i_src_y    = Y_W'(sy);
    i_num_pkts = CNT_W'(num);
    i_gap      = GAP_W'(gap);
    i_start    = 1'b1;
    tick();
    i_start    = 1'b0;
  endtask

  task automatic wait_done(input int lim, input int exp_tx);
    int k = 0;
    while (!o_done && k < lim) begin
      tick();
      k++;
    end
    check("done_reached", 32'(o_done), 32'd1);
    check("tx_count", 32'(o_tx_count), 32'(exp_tx));
    check("busy_off", 32'(o_busy), 32'd0);
    check("queue_drained", 32'(exp_q.size()), 32'd0);
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_data"}, 32'(o_data), 32'd0);
    check({tag, "_valid"}, 32'(o_data_valid), 32'd0);
    check({tag, "_busy"}, 32'(o_busy), 32'd0);
    check({tag, "_done"}, 32'(o_done), 32'd0);
    check({tag, "_tx"}, 32'(o_tx_count), 32'd0);
    check({tag, "_rx"}, 32'(o_rx_count), 32'd0);
    check({tag, "_err"}, 32'(o_err_count), 32'd0);
  endtask

  initial begin
    rstn = 1'b0; i_start = 1'b0; i_pattern = '0; i_num_pkts = '0; i_gap = '0;
    i_src_x = '0; i_src_y = '0; i_data = '0; i_data_valid = 1'b0;
    tick(); tick();
    check_all_zero("reset");
    rstn = 1'b1;
    tick();

    // Bit-complement, back-to-back: literal flit values
    ready_mode = 1;
    run(2, 1, 2, 3, 0);
    check("bc_flit0", 32'(o_data), 32'h0069);
    tick();
    check("bc_flit1", 32'(o_data), 32'h0169);
    tick();
    check("bc_flit2", 32'(o_data), 32'h0269);
    check("bc_not_done_yet", 32'(o_done), 32'd0);
    tick();
    check("bc_done_next", 32'(o_done), 32'd1);
    wait_done(10, 3);

    // Same run with ready held low on flit 0
    ready_mode = 0;
    run(2, 1, 2, 3, 0);
    for (int i = 0; i < 4; i++) begin
      check("stall_valid", 32'(o_data_valid), 32'd1);
      check("stall_data", 32'(o_data), 32'h0069);
      check("stall_tx", 32'(o_tx_count), 32'd0);
      tick();
    end
    ready_mode = 1;
    wait_done(20, 3);

    // Gap of 3
    run(2, 1, 2, 2, 3);
    wait_done(30, 2);

    // Zero-packet run
    run(3, 2, 2, 0, 0);
    check("num0_done", 32'(o_done), 32'd1);
    check("num0_valid", 32'(o_data_valid), 32'd0);
    tick(); tick();

    // Start pulses during GEN/GAP are ignored
    run(3, 3, 1, 5, 2);
    tick();
    i_start = 1'b1; i_num_pkts = 1; i_pattern = 2'd0; i_gap = 0;
    tick(); tick();
    i_start = 1'b0;
    wait_done(60, 5);

    // Randomized runs
    ready_mode = 2;
    for (int r = 0; r < 8; r++) begin
      int num = $urandom_range(1, 20);
      run($urandom_range(0, 3), $urandom_range(0, 3), $urandom_range(0, 3), num,
          $urandom_range(0, 3));
      wait_done(400, num);
    end

    // Long uniform run: payload wraps past 255
    run(0, $urandom_range(0, 3), $urandom_range(0, 3), 300, 0);
    wait_done(3000, 300);

    // Random ejection traffic
    i_src_x = X_W'($urandom_range(0, 3));
    i_src_y = Y_W'($urandom_range(0, 3));
    for (int i = 0; i < 30; i++) begin
      i_data_valid = 1'($urandom_range(0, 1));
      i_data       = 16'($urandom);
      if (i_data_valid) begin
        m_rx++;
        if (((i_data >> 4) & 16'h3) != 16'(i_src_x) || ((i_data >> 6) & 16'h3) != 16'(i_src_y))
          m_err++;
      end
      tick();
    end
    i_data_valid = 1'b0;
    tick();
    check("rx_count_rand", 32'(o_rx_count), 32'(m_rx));
`ifdef NOC_TG_CHECK_EN
    check("err_count_rand", 32'(o_err_count), 32'(m_err));
`else
    check("err_count_off", 32'(o_err_count), 32'd0);
`endif

    // Directed ejection against src (0,0)
    i_src_x = '0; i_src_y = '0;
    i_data_valid = 1'b1; i_data = 16'h0005;
    tick();
    i_data = 16'h0015;
    tick();
    i_data_valid = 1'b0;
    tick();
    check("rx_count_dir", 32'(o_rx_count), 32'(m_rx + 2));
`ifdef NOC_TG_CHECK_EN
    check("err_count_dir", 32'(o_err_count), 32'(m_err + 1));
`else
    check("err_count_dir_off", 32'(o_err_count), 32'd0);
`endif

    // Mid-run reset drops the run
    ready_mode = 2;
    run(0, 1, 1, 50, 0);
    for (int i = 0; i < 15; i++) tick();
    ready_mode = 0;
    tick();
    rstn = 1'b0;
    tick();
    check_all_zero("midrun_reset");
    exp_q.delete();
    m_lfsr = 16'hACE1;
    rstn = 1'b1;
    tick();

    // LFSR reseeded: fresh run matches model from seed
    ready_mode = 2;
    run(0, 0, 3, 12, 1);
    wait_done(200, 12);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
